// File: rtl/symbol_block_deserializer_if.sv
// Symbol-in / block-out bus of the symbol block deserializer.
// The master side produces symbols and consumes blocks. The slave side is the deserializer.
interface symbol_block_deserializer_if #(
  parameter int SYM_W      = 2,
  parameter int BLK_W      = 128,
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [SYM_W-1:0] symbol_in;
  logic             symbol_valid;
  logic             frame_start;
  logic [BLK_W-1:0] block_out;
  logic             block_valid;
  logic             block_ready;
  logic [LW-1:0]    fifo_level;
  logic             overflow;
  logic             sync_err;

  modport master (
    output symbol_in, symbol_valid, frame_start, block_ready,
    input  block_out, block_valid, fifo_level, overflow, sync_err
  );

  modport slave (
    input  symbol_in, symbol_valid, frame_start, block_ready,
    output block_out, block_valid, fifo_level, overflow, sync_err
  );
endinterface

// File: rtl/symbol_block_deserializer.sv
// Packs SYM_W-bit symbols into BLK_W-bit blocks and queues finished blocks
// in a first-word-fall-through FIFO of FIFO_DEPTH entries.
// A frame_start resynchronises the packer. Dropped blocks and discarded
// partial blocks are flagged with one-cycle overflow and sync_err pulses.
// Optional macro SYMBOL_DESER_DROP_CNT_EN adds a saturating drop_cnt output.
// drop_cnt counts overflow events plus sync_err events.
module symbol_block_deserializer #(
  parameter int SYM_W      = 2,
  parameter int BLK_W      = 128,
  parameter int FIFO_DEPTH = 4,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  symbol_block_deserializer_if.slave bus
`ifdef SYMBOL_DESER_DROP_CNT_EN
  ,
  output logic [15:0] drop_cnt
`endif
);

  localparam int SYMS = BLK_W / SYM_W;
  localparam int CW   = (SYMS > 1) ? $clog2(SYMS) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_SYM = CW'(SYMS - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);

  logic [CW-1:0]    sym_cnt;
  logic [BLK_W-1:0] shift_reg;
  logic [BLK_W-1:0] sym_ins;
  logic [BLK_W-1:0] shift_next;
  logic             frame_discard;
  logic             complete;

  logic [BLK_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      fifo_count;
  logic             fifo_full;
  logic             pop;
  logic             push;
  logic             drop;
  logic             overflow_q;
  logic             sync_err_q;

  // Position the incoming symbol and form the shifted register image.
  // A frame_start that interrupts a partial block restarts the packer with only the current symbol.
  // A completing symbol forms the block together with the earlier symbols.
  // A full FIFO accepts the block only when the head is popped in the same cycle.
  always_comb begin
    sym_ins       = '0;
    shift_next    = '0;
    frame_discard = 1'b0;
    complete      = 1'b0;
    if (MSB_FIRST) begin
      sym_ins    = BLK_W'(bus.symbol_in);
      shift_next = (shift_reg << SYM_W) | sym_ins;
    end else begin
      sym_ins    = BLK_W'(bus.symbol_in) << (BLK_W - SYM_W);
      shift_next = (shift_reg >> SYM_W) | sym_ins;
    end
    frame_discard = bus.symbol_valid && bus.frame_start && (sym_cnt != '0);
    complete      = bus.symbol_valid && !frame_discard && (sym_cnt == LAST_SYM);
  end

  assign fifo_full = (fifo_count == FULL_LVL);
  assign pop       = (fifo_count != '0) && bus.block_ready;
  assign push      = complete && (!fifo_full || pop);
  assign drop      = complete && fifo_full && !pop;

  // Symbol counter and shift register: advance on every valid symbol, restart on resync.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sym_cnt   <= '0;
      shift_reg <= '0;
    end else if (bus.symbol_valid) begin
      if (frame_discard) begin
        sym_cnt   <= CW'(1);
        shift_reg <= sym_ins;
      end else if (complete) begin
        sym_cnt   <= '0;
        shift_reg <= '0;
      end else begin
        sym_cnt   <= sym_cnt + CW'(1);
        shift_reg <= shift_next;
      end
    end
  end

  // Block storage: written on accepted pushes only. Stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift_next;
  end

  // FIFO pointers and occupancy. A simultaneous push and pop leaves the level unchanged.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (AW + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (AW + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Registered one-cycle error pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      overflow_q <= drop;
      sync_err_q <= frame_discard;
    end
  end

`ifdef SYMBOL_DESER_DROP_CNT_EN
  // Saturating count of lost data events. Drop and resync can never occur in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_cnt <= '0;
    end else if ((drop || frame_discard) && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

  assign bus.block_valid = (fifo_count != '0);
  assign bus.block_out   = (fifo_count != '0) ? mem[rd_ptr] : '0;
  assign bus.fifo_level  = fifo_count;
  assign bus.overflow    = overflow_q;
  assign bus.sync_err    = sync_err_q;

endmodule

// File: tb/tb_symbol_block_deserializer.sv
// Scoreboard bench for symbol_block_deserializer.
// It drives one MSB-first and one LSB-first instance with identical stimulus.
// Expected blocks are queued when stimulus is issued.
// A negedge monitor pops and compares them on every DUT pop.
module tb_symbol_block_deserializer;
  localparam int SYM_W = 2;
  localparam int BLK_W = 128;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  symbol_block_deserializer_if #(.SYM_W(SYM_W), .BLK_W(BLK_W), .FIFO_DEPTH(DEPTH)) msb_bus ();
  symbol_block_deserializer_if #(.SYM_W(SYM_W), .BLK_W(BLK_W), .FIFO_DEPTH(DEPTH)) lsb_bus ();

`ifdef SYMBOL_DESER_DROP_CNT_EN
  logic [15:0] drop_msb;
  logic [15:0] drop_lsb;
`endif

  symbol_block_deserializer #(.SYM_W(SYM_W), .BLK_W(BLK_W), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .bus(msb_bus)
`ifdef SYMBOL_DESER_DROP_CNT_EN
    , .drop_cnt(drop_msb)
`endif
  );

  symbol_block_deserializer #(.SYM_W(SYM_W), .BLK_W(BLK_W), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .bus(lsb_bus)
`ifdef SYMBOL_DESER_DROP_CNT_EN
    , .drop_cnt(drop_lsb)
`endif
  );

  int n_checks = 0;
  int n_fail = 0;
  int ovf_msb = 0, ovf_lsb = 0, sync_msb = 0, sync_lsb = 0;
  logic [127:0] exp_msb[$];
  logic [127:0] exp_lsb[$];

  // Hand-computed block patterns: a byte repeated 16 times, seen MSB-first,
  // and the same symbol stream packed LSB-first.
  logic [127:0] pat_msb [5] = '{{16{8'h01}}, {16{8'h02}}, {16{8'h03}}, {16{8'h04}}, {16{8'h05}}};
  logic [127:0] pat_lsb [5] = '{{16{8'h40}}, {16{8'h80}}, {16{8'hC0}}, {16{8'h10}}, {16{8'h50}}};

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare every popped block with the scoreboard and count error pulses.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (msb_bus.block_valid && msb_bus.block_ready) begin
        if (exp_msb.size() == 0) begin
          n_checks++; n_fail++;
          $display("[TB] FAIL msb_unexpected_block: got %h expected none", msb_bus.block_out);
        end else checkOutput("msb_block", msb_bus.block_out, exp_msb.pop_front());
      end
      if (lsb_bus.block_valid && lsb_bus.block_ready) begin
        if (exp_lsb.size() == 0) begin
          n_checks++; n_fail++;
          $display("[TB] FAIL lsb_unexpected_block: got %h expected none", lsb_bus.block_out);
        end else checkOutput("lsb_block", lsb_bus.block_out, exp_lsb.pop_front());
      end
    end
    if (msb_bus.overflow === 1'b1) ovf_msb++;
    if (lsb_bus.overflow === 1'b1) ovf_lsb++;
    if (msb_bus.sync_err === 1'b1) sync_msb++;
    if (lsb_bus.sync_err === 1'b1) sync_lsb++;
  end

  task automatic applyStimulus(input logic [1:0] sym, input logic fs);
    msb_bus.symbol_in = sym;  lsb_bus.symbol_in = sym;
    msb_bus.frame_start = fs; lsb_bus.frame_start = fs;
    msb_bus.symbol_valid = 1'b1; lsb_bus.symbol_valid = 1'b1;
    @(posedge clk); #1;
    msb_bus.symbol_valid = 1'b0; lsb_bus.symbol_valid = 1'b0;
    msb_bus.frame_start = 1'b0;  lsb_bus.frame_start = 1'b0;
  endtask

  task automatic set_ready(input logic r);
    msb_bus.block_ready = r;
    lsb_bus.block_ready = r;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_range(input logic [127:0] v, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) applyStimulus(v[127-2*i -: 2], 1'b0);
  endtask

  task automatic send_block(input logic [127:0] v);
    send_range(v, 0, 63);
  endtask

  task automatic expect_block(input logic [127:0] vm, input logic [127:0] vl);
    exp_msb.push_back(vm);
    exp_lsb.push_back(vl);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    msb_bus.symbol_in = '0; lsb_bus.symbol_in = '0;
    msb_bus.symbol_valid = 1'b0; lsb_bus.symbol_valid = 1'b0;
    msb_bus.frame_start = 1'b0; lsb_bus.frame_start = 1'b0;
    set_ready(1'b0);

    // Reset state
    idle(2);
    checkOutput("rst_block_valid", 128'(msb_bus.block_valid), 128'd0);
    checkOutput("rst_fifo_level", 128'(msb_bus.fifo_level), 128'd0);
    checkOutput("rst_block_out", msb_bus.block_out, 128'd0);
    checkOutput("rst_overflow", 128'(msb_bus.overflow), 128'd0);
    checkOutput("rst_sync_err", 128'(lsb_bus.sync_err), 128'd0);
    reset = 1'b1;
    idle(1);

    // Basic: 64 symbols of 01, block visible one cycle after last symbol
    set_ready(1'b1);
    expect_block({64{2'b01}}, {64{2'b01}});
    for (int i = 0; i < 64; i++) applyStimulus(2'b01, 1'b0);
    checkOutput("basic_valid", 128'(msb_bus.block_valid), 128'd1);
    checkOutput("basic_block", msb_bus.block_out, 128'h5555_5555_5555_5555_5555_5555_5555_5555);
    checkOutput("basic_level", 128'(msb_bus.fifo_level), 128'd1);
    idle(1);
    checkOutput("basic_level_after_pop", 128'(msb_bus.fifo_level), 128'd0);

    // Symbol order: first symbol 11, then zeros
    expect_block({2'b11, 126'd0}, 128'h3);
    applyStimulus(2'b11, 1'b0);
    for (int i = 1; i < 64; i++) applyStimulus(2'b00, 1'b0);
    checkOutput("order_lsb_block", lsb_bus.block_out, 128'h3);
    checkOutput("order_msb_block", msb_bus.block_out, {2'b11, 126'd0});
    idle(2);

    // Backpressure and overflow: five blocks into a four-entry FIFO
    set_ready(1'b0);
    for (int k = 0; k < 4; k++) begin
      expect_block(pat_msb[k], pat_lsb[k]);
      send_block(pat_msb[k]);
    end
    send_block(pat_msb[4]);
    checkOutput("ovf_level", 128'(msb_bus.fifo_level), 128'd4);
    checkOutput("ovf_head_kept", msb_bus.block_out, pat_msb[0]);
    checkOutput("ovf_head_kept_lsb", lsb_bus.block_out, pat_lsb[0]);
    idle(2);
    checkOutput("ovf_pulse_msb", 128'(ovf_msb), 128'd1);
    checkOutput("ovf_pulse_lsb", 128'(ovf_lsb), 128'd1);
    set_ready(1'b1);
    idle(6);
    checkOutput("ovf_drained_level", 128'(msb_bus.fifo_level), 128'd0);
    checkOutput("ovf_queue_empty", 128'(exp_msb.size()), 128'd0);

    // Full FIFO with pop in the completion cycle: block 5 accepted
    set_ready(1'b0);
    for (int k = 0; k < 4; k++) begin
      expect_block(pat_msb[k], pat_lsb[k]);
      send_block(pat_msb[k]);
    end
    expect_block(pat_msb[4], pat_lsb[4]);
    send_range(pat_msb[4], 0, 62);
    set_ready(1'b1);
    send_range(pat_msb[4], 63, 63);
    set_ready(1'b0);
    checkOutput("fullpop_level", 128'(msb_bus.fifo_level), 128'd4);
    checkOutput("fullpop_level_lsb", 128'(lsb_bus.fifo_level), 128'd4);
    idle(2);
    checkOutput("fullpop_no_ovf", 128'(ovf_msb), 128'd1);
    set_ready(1'b1);
    idle(6);
    checkOutput("fullpop_queue_empty", 128'(exp_msb.size() + exp_lsb.size()), 128'd0);

    // Resync after 10 symbols: new block contains only post-resync symbols
    for (int i = 0; i < 10; i++) applyStimulus(2'b11, 1'b0);
    expect_block({2'b01, {63{2'b10}}}, {{63{2'b10}}, 2'b01});
    applyStimulus(2'b01, 1'b1);
    for (int i = 0; i < 62; i++) applyStimulus(2'b10, 1'b0);
    checkOutput("resync_not_early", 128'(msb_bus.block_valid), 128'd0);
    applyStimulus(2'b10, 1'b0);
    checkOutput("resync_complete", 128'(msb_bus.block_valid), 128'd1);
    idle(2);
    checkOutput("resync_pulse_msb", 128'(sync_msb), 128'd1);
    checkOutput("resync_pulse_lsb", 128'(sync_lsb), 128'd1);
    checkOutput("resync_no_ovf", 128'(ovf_lsb), 128'd1);
`ifdef SYMBOL_DESER_DROP_CNT_EN
    checkOutput("drop_cnt_msb", 128'(drop_msb), 128'd2);
    checkOutput("drop_cnt_lsb", 128'(drop_lsb), 128'd2);
`endif

    // Reset mid-operation: 3 queued blocks and 20 partial symbols discarded
    set_ready(1'b0);
    for (int k = 0; k < 3; k++) send_block(pat_msb[k]);
    send_range(pat_msb[3], 0, 19);
    checkOutput("pre_reset_level", 128'(msb_bus.fifo_level), 128'd3);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    checkOutput("mid_rst_valid", 128'(msb_bus.block_valid), 128'd0);
    checkOutput("mid_rst_level", 128'(lsb_bus.fifo_level), 128'd0);
    checkOutput("mid_rst_overflow", 128'(msb_bus.overflow), 128'd0);
    checkOutput("mid_rst_sync_err", 128'(msb_bus.sync_err), 128'd0);
`ifdef SYMBOL_DESER_DROP_CNT_EN
    checkOutput("drop_cnt_cleared", 128'(drop_msb), 128'd0);
`endif
    idle(2);
    checkOutput("mid_rst_no_pulses", 128'(ovf_msb + sync_msb), 128'd2);
    expect_block(pat_msb[2], pat_lsb[2]);
    send_block(pat_msb[2]);
    checkOutput("post_rst_valid", 128'(msb_bus.block_valid), 128'd1);
    checkOutput("post_rst_level", 128'(msb_bus.fifo_level), 128'd1);
    set_ready(1'b1);
    idle(3);
    checkOutput("post_rst_drained", 128'(msb_bus.fifo_level), 128'd0);
    checkOutput("final_queue_empty", 128'(exp_msb.size() + exp_lsb.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/symbol_block_deserializer.md
Name: symbol_block_deserializer

Overview:
Parametrised successor to the fixed 2-bit/128-bit symbol deserializer on the modem receive path. Packs SYM_W-bit demapper symbols into BLK_W-bit cipher blocks and queues completed blocks in a FIFO_DEPTH-entry buffer, so bursts survive a stalled decryptor. Adds frame resynchronisation, selectable symbol order, a FIFO level output and explicit overflow/sync-error signalling, where the old block silently overwrote unsent data.

Parameters:
SYM_W, 2, bits per input symbol (1..8); BLK_W must be an integer multiple of SYM_W.
BLK_W, 128, output block width.
FIFO_DEPTH, 4, completed-block buffer entries (power of 2, >=2).
MSB_FIRST, 1, 1: first symbol lands in block_out[BLK_W-1 -: SYM_W]; 0: first symbol lands in block_out[SYM_W-1:0].

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-low; sampled on rising clk edge
symbol_in  in  SYM_W  symbol data
symbol_valid  in  1  symbol_in qualifier, one symbol per cycle max
frame_start  in  1  marks the current symbol as first of a new block; meaningful only with symbol_valid
block_out  out  BLK_W  FIFO head block
block_valid  out  1  FIFO non-empty
block_ready  in  1  consumer accept; pop when block_valid && block_ready
fifo_level  out  $clog2(FIFO_DEPTH)+1  stored block count
overflow  out  1  one-cycle pulse: completed block dropped, FIFO full
sync_err  out  1  one-cycle pulse: frame_start discarded a partial block

Behaviour:
- SYMS = BLK_W/SYM_W; symbol counter width $clog2(SYMS); shift register BLK_W bits.
- Reset (reset==0 at clk edge): counter=0, shift register=0, FIFO empty, block_out=0, block_valid=0, fifo_level=0, overflow=0, sync_err=0. Applies mid-block and mid-burst; partial block and all queued blocks are discarded, with no pulse.
- Assembly: each symbol_valid cycle shifts symbol_in in. MSB_FIRST=1 shifts left, inserting at the LSB end. MSB_FIRST=0 shifts right, inserting at the MSB end. The counter increments.
- Completion: a symbol_valid cycle with counter==SYMS-1 forms the block from the shift register plus the current symbol. That cycle pushes the block to the FIFO and wraps the counter to 0.
- Latency: with the FIFO empty, block_valid=1 and block_out show the block on the clock edge that registers the last symbol (cycle after the last symbol is presented).
- FIFO: first-word-fall-through. block_out always equals the head entry. block_out holds stable while block_valid && !block_ready.
- Pop and push in the same cycle: both are performed and fifo_level is unchanged. When the FIFO is full, a same-cycle pop frees the slot and the push is accepted.
- Full, no pop, completion: the new block is dropped, the FIFO is unchanged (oldest data kept) and overflow pulses for exactly one cycle. The counter still wraps to 0.
- frame_start && symbol_valid: the current symbol becomes symbol 0 of a new block and the counter becomes 1. If the prior counter was nonzero, the partial block is discarded and sync_err pulses for one cycle. frame_start has priority over completion: with counter==SYMS-1, no block is pushed and sync_err pulses.
- frame_start without symbol_valid is ignored.
- SYMS==1 degenerate case: every symbol completes a block.
- block_ready while empty: no effect.

Optional Feature:
Macro SYMBOL_DESER_DROP_CNT_EN.
- Defined: adds output drop_cnt [15:0], a saturating count (holds at 16'hFFFF) of overflow events plus sync_err events. Cleared only by reset.
- Undefined: the port and the counter do not exist. All other behaviour is identical.

Test Plan:
- Basic: SYM_W=2, BLK_W=128, MSB_FIRST=1. Drive 64 symbols 2'b01 then hold block_ready=1 -> one cycle after the last symbol, block_out=128'h5555...5555, block_valid=1. Popped the next cycle; fifo_level returns to 0.
- Order: MSB_FIRST=0. Drive symbol 0 = 2'b11, symbols 1..63 = 2'b00 -> block_out=128'h...0003, i.e. bits [1:0]=2'b11 and all other bits 0.
- Backpressure/overflow: block_ready=0. Drive 5 blocks with values 1..5 (each block all-constant pattern) -> fifo_level=4. overflow pulses once at completion of block 5. Then block_ready=1 pops blocks 1,2,3,4 in order; block 5 is absent.
- Full with simultaneous pop: fill to 4, then assert block_ready in the exact cycle block 5 completes -> no overflow, fifo_level stays 4, block 5 appears last.
- Resync: after 10 symbols, assert frame_start with a symbol -> sync_err pulses once. The next block completes 63 symbols later and contains only post-resync symbols.
- Reset mid-operation: 3 queued blocks plus 20 partial symbols, then reset=0 for one edge -> block_valid=0, fifo_level=0, no overflow/sync_err. A fresh 64-symbol block completes normally afterwards.
